// File: rtl/control_pkg.sv
// Shared types for the host-link ROM loader and its UART receiver.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package control_pkg;

    typedef enum logic [2:0] {
        ST_HDR,
        ST_DATA,
        ST_WRITE,
        ST_DONE,
        ST_ERROR
    } load_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    localparam int HDR_BYTES      = 4;
    localparam int UART_DATA_BITS = 8;

    // Length arrives LSB first: each new byte enters at the top and the older bytes slide down.
    function automatic logic [31:0] shift_len(input logic [31:0] len, input logic [7:0] b);
        return {b, len[31:8]};
    endfunction

endpackage

// File: rtl/uart_rom_loader_if.sv
// ROM write port: address/data/write_en held by the writer until mem_ready.
// Latency: n/a (wiring only).
// Backpressure: writer stalls while mem_ready is low.
interface uart_rom_loader_if;
    logic [31:0] mem_addr;
    logic [7:0]  mem_data_in;
    logic        mem_write_en;
    logic        mem_ready;

    modport master (output mem_addr, output mem_data_in, output mem_write_en, input mem_ready);
    modport slave  (input mem_addr, input mem_data_in, input mem_write_en, output mem_ready);
endinterface

// File: rtl/uart_rx.sv
// 8N1 receiver: synchroniser, mid-bit sampling timer, LSB-first shifter.
// Latency: byte_valid/frame_err pulse one clk after the stop-bit sample.
// Backpressure: none; each byte is a single-cycle pulse and must be taken immediately.
module uart_rx
    import control_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_serial,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam logic [15:0] HALF_CNT = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] FULL_CNT = 16'(CLKS_PER_BIT - 1);

    logic        sync1, sync2, rx_prev;
    rx_state_t   state, state_nxt;
    logic [15:0] cnt, cnt_nxt;
    logic [2:0]  bit_idx, bit_idx_nxt;
    logic [7:0]  shreg, shreg_nxt;
    logic        byte_valid_nxt, frame_err_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            sync1   <= rx_serial;
            sync2   <= sync1;
            rx_prev <= sync2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RX_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            bit_idx    <= bit_idx_nxt;
            shreg      <= shreg_nxt;
            byte_valid <= byte_valid_nxt;
            frame_err  <= frame_err_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        bit_idx_nxt    = bit_idx;
        shreg_nxt      = shreg;
        byte_valid_nxt = 1'b0;
        frame_err_nxt  = 1'b0;
        case (state)
            RX_IDLE: begin
                if (rx_prev && !sync2) begin
                    state_nxt = RX_START;
                    cnt_nxt   = '0;
                end
            end
            RX_START: begin
                // A start bit that is high again at mid-bit was line noise.
                if (cnt == HALF_CNT) begin
                    cnt_nxt     = '0;
                    bit_idx_nxt = '0;
                    state_nxt   = sync2 ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            RX_DATA: begin
                if (cnt == FULL_CNT) begin
                    cnt_nxt   = '0;
                    shreg_nxt = {sync2, shreg[7:1]};
                    if (bit_idx == 3'(UART_DATA_BITS - 1)) begin
                        state_nxt = RX_STOP;
                    end else begin
                        bit_idx_nxt = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            RX_STOP: begin
                if (cnt == FULL_CNT) begin
                    cnt_nxt        = '0;
                    state_nxt      = RX_IDLE;
                    byte_valid_nxt = sync2;
                    frame_err_nxt  = !sync2;
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            default: state_nxt = RX_IDLE;
        endcase
    end

    assign byte_data = shreg;

endmodule

// File: rtl/uart_rom_loader.sv
// Loads a length-prefixed image from the host UART into ROM, then releases the cpu via load_done.
// Latency: stop-bit sample to mem_write_en high is 2 clk.
// Backpressure: holds each write until mem_ready; a byte arriving before the ack is an overrun.
module uart_rom_loader
    import control_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 434,
    parameter logic [31:0] BASE_ADDR    = 32'h0,
    parameter logic [31:0] MAX_BYTES    = 32'h1_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_serial,
    uart_rom_loader_if.master mem,
    output logic              load_done,
    output logic              load_error,
    output logic [31:0]       bytes_loaded
);

    logic       byte_valid, frame_err;
    logic [7:0] byte_data;

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk        (clk),
        .rst        (rst),
        .rx_serial  (rx_serial),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_err  (frame_err)
    );

    load_state_t state, state_nxt;
    logic [1:0]  hdr_cnt, hdr_cnt_nxt;
    logic [31:0] len, len_nxt;
    logic [31:0] cnt_nxt;
    logic [31:0] addr, addr_nxt;
    logic [7:0]  data, data_nxt;
    logic        we, we_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_HDR;
            hdr_cnt      <= '0;
            len          <= '0;
            bytes_loaded <= '0;
            addr         <= '0;
            data         <= '0;
            we           <= 1'b0;
        end else begin
            state        <= state_nxt;
            hdr_cnt      <= hdr_cnt_nxt;
            len          <= len_nxt;
            bytes_loaded <= cnt_nxt;
            addr         <= addr_nxt;
            data         <= data_nxt;
            we           <= we_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        hdr_cnt_nxt = hdr_cnt;
        len_nxt     = len;
        cnt_nxt     = bytes_loaded;
        addr_nxt    = addr;
        data_nxt    = data;
        we_nxt      = we;
        case (state)
            ST_HDR: begin
                if (frame_err) begin
                    state_nxt = ST_ERROR;
                end else if (byte_valid) begin
                    len_nxt     = shift_len(len, byte_data);
                    hdr_cnt_nxt = hdr_cnt + 2'd1;
                    if (hdr_cnt == 2'(HDR_BYTES - 1)) begin
                        if (len_nxt == 32'd0)          state_nxt = ST_DONE;
                        else if (len_nxt > MAX_BYTES)  state_nxt = ST_ERROR;
                        else                           state_nxt = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (frame_err) begin
                    state_nxt = ST_ERROR;
                end else if (byte_valid) begin
                    addr_nxt  = BASE_ADDR + bytes_loaded;
                    data_nxt  = byte_data;
                    we_nxt    = 1'b1;
                    state_nxt = ST_WRITE;
                end
            end
            ST_WRITE: begin
                // A new byte before the ack has nowhere to go; abort rather than drop it.
                if (frame_err || byte_valid) begin
                    we_nxt    = 1'b0;
                    state_nxt = ST_ERROR;
                end else if (mem.mem_ready) begin
                    we_nxt    = 1'b0;
                    cnt_nxt   = bytes_loaded + 32'd1;
                    state_nxt = (cnt_nxt == len) ? ST_DONE : ST_DATA;
                end
            end
            ST_DONE:  we_nxt = 1'b0;
            ST_ERROR: we_nxt = 1'b0;
            default: begin
                we_nxt    = 1'b0;
                state_nxt = ST_ERROR;
            end
        endcase
    end

    assign mem.mem_addr     = addr;
    assign mem.mem_data_in  = data;
    assign mem.mem_write_en = we;
    assign load_done        = (state == ST_DONE);
    assign load_error       = (state == ST_ERROR);

endmodule
